fft_bin_serializer: RTL and testbench
=====================================

// Module: fft_bin_serializer
// PURPOSE
//  Sits directly downstream of the 8-point FFT core. Accepts one 512-bit frame of 8 complex bins
//  per AXI-Stream beat and emits 8 beats, one bin per beat, on a narrow stream.
//  Per component: arithmetic right shift with rounding, then saturation to OUT_W bits.
//  Provides tlast and bin index for framing, plus a sticky saturation flag for software.
// PARAMETERS
//  IN_W   32  width of each real/imag component in the input frame (signed)
//  OUT_W  16  width of each real/imag component on output (signed, 2..IN_W)
//  SHIFT  0   arithmetic right shift applied before saturation (0..IN_W-2)
// PORTS
//  s_axis_aclk     in   1         sole clock, all logic rising-edge
//  s_axis_aresetn  in   1         asynchronous reset, active-low
//  s_axis_tvalid   in   1         input frame valid
//  s_axis_tready   out  1         input frame accepted when tvalid & tready
//  s_axis_tdata    in   16*IN_W   {X7r,X7i,...,X0r,X0i}; bin k real [IN_W*(2k+2)-1 -: IN_W], imag [IN_W*(2k+1)-1 -: IN_W]
//  m_axis_tvalid   out  1         output beat valid
//  m_axis_tready   in   1         downstream ready
//  m_axis_tdata    out  2*OUT_W   {real, imag} of current bin, real in upper half
//  m_axis_tlast    out  1         high on bin 7 beat
//  m_axis_tuser    out  3         bin index 0..7 of current beat
//  sat_clr         in   1         synchronous clear of sat_sticky
//  sat_sticky      out  1         set when any transferred component saturated
// BEHAVIOUR
//  Reset (async, aresetn low): state=IDLE, bin_cnt=0, m_axis_tvalid=0, sat_sticky=0, frame reg=0;
//   s_axis_tready=0 while aresetn low; m_axis_tdata=0, tlast=0, tuser=0 follow from cleared regs.
//  States: IDLE (no frame held), SEND (frame held, bin_cnt = bin on output).
//  s_axis_tready = (state==IDLE) | (state==SEND & bin_cnt==7 & m_axis_tready). Combinational, no path from s_axis_tvalid.
//  IDLE & s accept: load frame, bin_cnt<=0, ->SEND. First beat valid the next cycle (latency 1).
//  SEND: m_axis_tvalid=1. On m handshake with bin_cnt<7: bin_cnt++.
//   On m handshake with bin_cnt==7: if s accept same cycle, load new frame, bin_cnt<=0, stay SEND (zero-bubble);
//   else ->IDLE, m_axis_tvalid<=0.
//  No handshake: tdata/tlast/tuser held stable while tvalid & !tready (AXIS rule).
//  Sustained throughput: 1 frame per 8 cycles with m_axis_tready held high.
//  m_axis_tdata/tlast/tuser decode combinationally from frame reg and bin_cnt only (no input-to-output path).
//  tuser=bin_cnt; tlast=(bin_cnt==7).
//  Arithmetic, per component c (signed IN_W):
//   SHIFT>0: t = (c + 2**(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits (no wrap).
//   SHIFT=0: t = c.
//   out = t > 2**(OUT_W-1)-1 ? max : t < -2**(OUT_W-1) ? min : t[OUT_W-1:0].
//  sat_sticky: set on a m handshake beat where either component clipped. sat_clr clears.
//   sat_clr and a set event in the same cycle: set wins.
//  Input s_axis_tdata sampled only on accept. Mid-frame reset drops the frame; no partial beats after release.
// TESTING
//  1 Reset: hold aresetn low 3 cycles with s_axis_tvalid=1 -> s_axis_tready=0, m_axis_tvalid=0, sat_sticky=0.
//  2 Frame, SHIFT=0 OUT_W=16, X_k=(k*100, -k) -> 8 beats, tuser 0..7, tdata bin3=0x012C_FFFD, tlast only on beat 7.
//  3 Saturation: X0r=40000, X0i=-40000 -> beat0 tdata=0x7FFF_8000, sat_sticky=1. sat_clr pulse -> 0.
//  4 Rounding, SHIFT=2: components 7,-7,-6,6 -> 2,-2,-1,2.
//  5 Back-to-back, m_axis_tready=1, s_axis_tvalid=1 -> 16 contiguous beats, no bubble, tready high only with bin7 beat.
//  6 Random m_axis_tready stalls -> outputs stable while stalled. Scoreboard vs reference model.
//    Reset asserted on bin 4 -> tvalid falls immediately; after release next frame starts at bin 0.

Source files
------------

// File: rtl/fft_bin_serializer_if.sv
// Stream bundle shared by the wide input side and the narrow output side of
// fft_bin_serializer.
//   tvalid / tready : handshake, transfer when both are high
//   tdata [W-1:0]   : payload
//   tlast           : last beat of a frame
//   tuser [2:0]     : bin index of the beat
// master drives valid/data/last/user; slave drives ready.
interface fft_bin_serializer_if #(
  parameter int W = 32
) ();
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;
  logic [2:0]   tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/fft_bin_serializer.sv
// Serializes one 8-bin complex FFT frame (one wide beat) into 8 narrow beats,
// one bin per beat. Each component is arithmetically shifted right with
// round-half-up, then saturated to OUT_W bits.
// Ports:
//   s_axis_aclk    : clock, rising edge
//   s_axis_aresetn : asynchronous reset, active low
//   s_axis         : input frame stream, tdata = {X7r,X7i,...,X0r,X0i}
//   m_axis         : output bin stream, tdata = {real, imag}, tuser = bin, tlast on bin 7
//   sat_clr        : synchronous clear of sat_sticky
//   sat_sticky     : set when a transferred beat had a clipped component
//
// state | meaning
// IDLE  | no frame held, ready for a new input frame
// SEND  | frame held, bin_cnt_q is the bin presented on m_axis
module fft_bin_serializer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 0
) (
  input  logic                        s_axis_aclk,
  input  logic                        s_axis_aresetn,
  fft_bin_serializer_if.slave         s_axis,
  fft_bin_serializer_if.master        m_axis,
  input  logic                        sat_clr,
  output logic                        sat_sticky
);

  typedef enum logic {IDLE, SEND} state_e;

  // Half an LSB of the shifted result; collapses to zero when SHIFT is 0.
  localparam logic [IN_W:0] RND = ({{IN_W{1'b0}}, 1'b1} << SHIFT) >> 1;

  state_e               state_q, state_d;
  logic [2:0]           bin_cnt_q, bin_cnt_d;
  logic [16*IN_W-1:0]   frame_q, frame_d;
  logic                 sat_q, sat_d;

  logic                 s_acc, m_hs, last_bin;
  logic [IN_W-1:0]      comp_re, comp_im;
  logic [OUT_W:0]       res_re, res_im;
  int                   bin_idx;

  // Returns {clipped, value}. The sum is one bit wider than the input so the
  // rounding offset can never wrap.
  function automatic logic [OUT_W:0] scale_sat(input logic [IN_W-1:0] c);
    logic signed [IN_W:0] t;
    logic [IN_W:OUT_W-1]  hi;
    t  = ($signed({c[IN_W-1], c}) + $signed(RND)) >>> SHIFT;
    hi = t[IN_W:OUT_W-1];
    // In range exactly when every bit above the output sign bit matches it.
    if ((&hi) || !(|hi)) begin
      scale_sat = {1'b0, t[OUT_W-1:0]};
    end else if (t[IN_W]) begin
      scale_sat = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      scale_sat = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

  assign last_bin = (bin_cnt_q == 3'd7);
  assign m_hs     = (state_q == SEND) && m_axis.tready;

  // Ready is forced low while reset is held so nothing is taken during reset.
  assign s_axis.tready = s_axis_aresetn &&
                         ((state_q == IDLE) || ((state_q == SEND) && last_bin && m_axis.tready));
  assign s_acc         = s_axis.tvalid && s_axis.tready;

  assign bin_idx = int'(bin_cnt_q);
  assign comp_re = frame_q[IN_W*(2*bin_idx+1) +: IN_W];
  assign comp_im = frame_q[IN_W*(2*bin_idx) +: IN_W];
  assign res_re  = scale_sat(comp_re);
  assign res_im  = scale_sat(comp_im);

  assign m_axis.tvalid = (state_q == SEND);
  assign m_axis.tdata  = {res_re[OUT_W-1:0], res_im[OUT_W-1:0]};
  assign m_axis.tlast  = last_bin;
  assign m_axis.tuser  = bin_cnt_q;
  assign sat_sticky    = sat_q;

  always_comb begin
    state_d   = state_q;
    bin_cnt_d = bin_cnt_q;
    frame_d   = frame_q;
    sat_d     = sat_q;
    case (state_q)
      IDLE: begin
        if (s_acc) begin
          frame_d   = s_axis.tdata;
          bin_cnt_d = 3'd0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (m_hs) begin
          if (!last_bin) begin
            bin_cnt_d = bin_cnt_q + 3'd1;
          end else if (s_acc) begin
            // Next frame lands while bin 7 leaves: no idle cycle between frames.
            frame_d   = s_axis.tdata;
            bin_cnt_d = 3'd0;
          end else begin
            bin_cnt_d = 3'd0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A clip on a transferred beat wins over a simultaneous clear.
    if (m_hs && (res_re[OUT_W] || res_im[OUT_W])) begin
      sat_d = 1'b1;
    end else if (sat_clr) begin
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q   <= IDLE;
      bin_cnt_q <= 3'd0;
      frame_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_cnt_q <= bin_cnt_d;
      frame_q   <= frame_d;
      sat_q     <= sat_d;
    end
  end

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Bench for fft_bin_serializer. Two instances (SHIFT=0 and SHIFT=2) share the
// same stimulus; a queue-based reference model predicts every output beat.
module tb_fft_bin_serializer;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  user;
    logic        last;
    logic        sat;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  user;
    int          cyc;
  } got_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic [511:0] s_data;
  logic         m_ready;
  logic         sat_clr;
  logic         sat0, sat2;

  int    n_chk  = 0;
  int    n_pass = 0;
  int    cyc    = 0;
  beat_t exp_q[2][$];
  got_t  got[2][$];
  bit    msat[2];

  int re[8];
  int im[8];

  always #5 clk = ~clk;

  fft_bin_serializer_if #(.W(512)) s0 ();
  fft_bin_serializer_if #(.W(32))  m0 ();
  fft_bin_serializer_if #(.W(512)) s2 ();
  fft_bin_serializer_if #(.W(32))  m2 ();

  assign s0.tvalid = s_valid;
  assign s0.tdata  = s_data;
  assign s0.tlast  = 1'b0;
  assign s0.tuser  = 3'd0;
  assign m0.tready = m_ready;
  assign s2.tvalid = s_valid;
  assign s2.tdata  = s_data;
  assign s2.tlast  = 1'b0;
  assign s2.tuser  = 3'd0;
  assign m2.tready = m_ready;

  fft_bin_serializer #(.IN_W(32), .OUT_W(16), .SHIFT(0)) dut0 (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis(s0), .m_axis(m0),
    .sat_clr(sat_clr), .sat_sticky(sat0));

  fft_bin_serializer #(.IN_W(32), .OUT_W(16), .SHIFT(2)) dut2 (
    .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis(s2), .m_axis(m2),
    .sat_clr(sat_clr), .sat_sticky(sat2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Reference scaling: round half up, then clip to 16-bit signed.
  function automatic logic [16:0] ref_comp(input longint c, input int sh);
    longint t;
    if (sh > 0) t = (c + (longint'(1) << (sh - 1))) >>> sh;
    else        t = c;
    if (t > 32767)  return {1'b1, 16'h7FFF};
    if (t < -32768) return {1'b1, 16'h8000};
    return {1'b0, t[15:0]};
  endfunction

  function automatic logic [511:0] pack_frame();
    logic [511:0] f;
    for (int k = 0; k < 8; k++) begin
      f[32*(2*k+1) +: 32] = re[k];
      f[32*(2*k) +: 32]   = im[k];
    end
    return f;
  endfunction

  function automatic int rand_comp();
    int sel;
    int edges[8];
    edges = '{32767, -32768, 32768, -32769, 131069, 131071, -131072, -131075};
    sel = int'($urandom_range(0, 3));
    case (sel)
      0:       return int'($urandom_range(0, 400)) - 200;
      1:       return ($urandom_range(0, 1) != 0) ? int'($urandom_range(30000, 140000))
                                                   : -int'($urandom_range(30000, 140000));
      2:       return int'($urandom);
      default: return edges[$urandom_range(0, 7)];
    endcase
  endfunction

  function automatic logic [511:0] rand_frame();
    for (int k = 0; k < 8; k++) begin
      re[k] = rand_comp();
      im[k] = rand_comp();
    end
    return pack_frame();
  endfunction

  task automatic push_frame(input int d);
    int          sh;
    logic [16:0] rr, ii;
    beat_t       b;
    sh = (d == 0) ? 0 : 2;
    for (int k = 0; k < 8; k++) begin
      rr = ref_comp(longint'($signed(s_data[32*(2*k+1) +: 32])), sh);
      ii = ref_comp(longint'($signed(s_data[32*(2*k) +: 32])), sh);
      b.data = {rr[15:0], ii[15:0]};
      b.sat  = rr[16] | ii[16];
      b.user = 3'(k);
      b.last = (k == 7);
      exp_q[d].push_back(b);
    end
  endtask

  task automatic mon(input int d, input logic tv, input logic sr, input logic [31:0] td,
                     input logic tl, input logic [2:0] tu, input logic st);
    bit    exp_v, exp_sr;
    beat_t b;
    got_t  g;
    exp_v  = (exp_q[d].size() > 0);
    exp_sr = !exp_v || ((exp_q[d].size() == 1) && m_ready);
    chk($sformatf("m_tvalid[%0d]", d), tv, exp_v);
    chk($sformatf("s_tready[%0d]", d), sr, exp_sr);
    chk($sformatf("sat_sticky[%0d]", d), st, msat[d]);
    if (exp_v) begin
      b = exp_q[d][0];
      chk($sformatf("tdata[%0d]", d), td, b.data);
      chk($sformatf("tuser[%0d]", d), tu, b.user);
      chk($sformatf("tlast[%0d]", d), tl, b.last);
    end
    if (exp_v && m_ready) begin
      b = exp_q[d].pop_front();
      g.data = td;
      g.user = tu;
      g.cyc  = cyc;
      got[d].push_back(g);
      if (b.sat) msat[d] = 1'b1;
      else if (sat_clr) msat[d] = 1'b0;
    end else if (sat_clr) begin
      msat[d] = 1'b0;
    end
    if (s_valid && exp_sr) push_frame(d);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_s_tready0", s0.tready, 1'b0);
      chk("rst_s_tready2", s2.tready, 1'b0);
      chk("rst_tvalid0", m0.tvalid, 1'b0);
      chk("rst_tvalid2", m2.tvalid, 1'b0);
      chk("rst_sat0", sat0, 1'b0);
      chk("rst_sat2", sat2, 1'b0);
      for (int d = 0; d < 2; d++) begin
        exp_q[d].delete();
        msat[d] = 1'b0;
      end
    end else begin
      mon(0, m0.tvalid, s0.tready, m0.tdata, m0.tlast, m0.tuser, sat0);
      mon(1, m2.tvalid, s2.tready, m2.tdata, m2.tlast, m2.tuser, sat2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got[0].delete();
    got[1].delete();
  endtask

  task automatic send(input logic [511:0] f);
    bit acc;
    acc     = 1'b0;
    s_data  = f;
    s_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      #2;
      acc = s_valid && s0.tready;
      tick();
    end
    s_valid = 1'b0;
    if (!acc) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #2;
      done = !m0.tvalid && !m2.tvalid;
    end
    chk("drain_done", done, 1'b1);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit acc, hit;
    logic [511:0] f;

    // Reset with a frame offered
    rst_n   = 1'b0;
    s_valid = 1'b1;
    s_data  = '1;
    m_ready = 1'b1;
    sat_clr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      re[k] = 0;
      im[k] = 0;
    end
    repeat (3) tick();
    s_valid = 1'b0;
    rst_n   = 1'b1;
    tick();

    // Basic frame, X_k = (k*100, -k)
    for (int k = 0; k < 8; k++) begin
      re[k] = k * 100;
      im[k] = -k;
    end
    clear_got();
    send(pack_frame());
    drain();
    chk("frame_beats", got[0].size(), 8);
    chk("frame_bin3", got[0][3].data, 32'h012C_FFFD);
    chk("frame_user7", got[0][7].user, 3'd7);

    // Saturation and sticky clear
    for (int k = 0; k < 8; k++) begin
      re[k] = 0;
      im[k] = 0;
    end
    re[0] = 40000;
    im[0] = -40000;
    clear_got();
    send(pack_frame());
    drain();
    chk("sat_beat0", got[0][0].data, 32'h7FFF_8000);
    chk("sat_set0", sat0, 1'b1);
    chk("sat_shift2_clear", sat2, 1'b0);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    @(negedge clk);
    #2;
    chk("sat_cleared0", sat0, 1'b0);
    tick();

    // Rounding with SHIFT=2
    for (int k = 0; k < 8; k++) begin
      re[k] = 0;
      im[k] = 0;
    end
    re[0] = 7;
    im[0] = -7;
    re[1] = -6;
    im[1] = 6;
    clear_got();
    send(pack_frame());
    drain();
    chk("round_bin0", got[1][0].data, 32'h0002_FFFE);
    chk("round_bin1", got[1][1].data, 32'hFFFF_0002);

    // Back-to-back frames, no bubble
    clear_got();
    m_ready = 1'b1;
    send(rand_frame());
    send(rand_frame());
    drain();
    chk("b2b_beats", got[0].size(), 16);
    chk("b2b_span", got[0][15].cyc - got[0][0].cyc, 15);

    // Random stalls and random frames
    for (int c = 0; c < 600; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      sat_clr = ($urandom_range(0, 15) == 0);
      if (!s_valid && ($urandom_range(0, 1) != 0)) begin
        s_data  = rand_frame();
        s_valid = 1'b1;
      end
      @(negedge clk);
      #2;
      acc = s_valid && s0.tready;
      tick();
      if (acc) s_valid = 1'b0;
    end
    s_valid = 1'b0;
    sat_clr = 1'b0;
    m_ready = 1'b1;
    drain();

    // Reset in the middle of a frame
    send(rand_frame());
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      hit = m0.tvalid && (m0.tuser == 3'd4);
      if (!hit) tick();
    end
    chk("mid_rst_reached_bin4", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid0", m0.tvalid, 1'b0);
    chk("mid_rst_tvalid2", m2.tvalid, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_got();
    f = rand_frame();
    send(f);
    drain();
    chk("post_rst_beats", got[0].size(), 8);
    chk("post_rst_first_bin", got[0][0].user, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
